simon_player_pad: RTL and testbench

Player-side counterpart of the Simon game controller. It turns four raw push-buttons into the controller's player handshake: a 2-bit playerNum plus a level playerPressed held for the whole debounced press. It also supplies the controller's 2-bit rand input from a free-running LFSR, and drives four feedback LEDs from either Simon's or the player's current press. Sits between the board buttons/LEDs and the Simon game controller, on the same 60 Hz clk.

---
 rtl/simon_player_pad.sv | 211 +++++++++++++++++++++
 tb/tb_simon_player_pad.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/simon_player_pad.sv
`default_nettype none
// ============================================================================
// Module      : simon_player_pad
// Description : Player-side pad for the Simon controller. Debounces four
//               buttons into a playerNum/playerPressed handshake, supplies an
//               LFSR random number, and drives one-hot feedback LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_player_pad #(
    parameter int         DEBOUNCE_TICKS = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] buttons_i,
    input  logic       simonTurn_i,
    input  logic [1:0] simonNum_i,
    input  logic       simonPressed_i,
    input  logic       gameOver_i,
    output logic [1:0] playerNum_o,
    output logic       playerPressed_o,
    output logic [1:0] rand_o,
    output logic [3:0] leds_o
);

    localparam logic [3:0] c_TICKS = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_PRESSED   = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] s1_q, s2_q;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cand_q, cand_d;
    logic [1:0] num_q, num_d;
    logic       pressed_q, pressed_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [4:0] blink_q;
    logic [3:0] leds_q, leds_d;

    logic       w_gate;
    logic       w_single;
    logic [1:0] w_idx;
    logic [3:0] w_cnt_inc;
    logic [3:0] w_cand_onehot;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    assign w_gate        = simonTurn_i | gameOver_i;
    assign w_cnt_inc     = cnt_q + 4'd1;
    assign w_cand_onehot = onehot(cand_q);

    // Exactly-one-button decode; several or none is not a candidate press.
    always_comb begin
        w_single = 1'b1;
        w_idx    = 2'd0;
        case (s2_q)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_single = 1'b0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= buttons_i;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= 2'd0;
            num_q     <= 2'd0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        num_d     = num_q;
        pressed_d = pressed_q;
        if (gameOver_i) begin
            state_d   = S_IDLE;
            cnt_d     = 4'd0;
            pressed_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!w_gate && w_single) begin
                        cand_d = w_idx;
                        if (c_TICKS == 4'd1) begin
                            state_d   = S_PRESSED;
                            cnt_d     = 4'd0;
                            num_d     = w_idx;
                            pressed_d = 1'b1;
                        end else begin
                            state_d = S_ARMING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_ARMING: begin
                    if (w_gate || (s2_q != w_cand_onehot)) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else if (w_cnt_inc == c_TICKS) begin
                        state_d   = S_PRESSED;
                        cnt_d     = 4'd0;
                        num_d     = cand_q;
                        pressed_d = 1'b1;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                // simonTurn is deliberately ignored here so a press in
                // progress always completes its release.
                S_PRESSED: begin
                    if (!s2_q[cand_q]) begin
                        if (c_TICKS == 4'd1) begin
                            state_d   = S_IDLE;
                            cnt_d     = 4'd0;
                            pressed_d = 1'b0;
                        end else begin
                            state_d = S_RELEASING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                S_RELEASING: begin
                    if (s2_q[cand_q]) begin
                        state_d = S_PRESSED;
                        cnt_d   = 4'd0;
                    end else if (w_cnt_inc == c_TICKS) begin
                        state_d   = S_IDLE;
                        cnt_d     = 4'd0;
                        pressed_d = 1'b0;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    cnt_d     = 4'd0;
                    pressed_d = 1'b0;
                end
            endcase
        end
    end

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; a nonzero seed keeps it off all-zero.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= LFSR_SEED;
            blink_q <= 5'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            blink_q <= blink_q + 5'd1;
        end
    end

    always_comb begin
        leds_d = 4'b0000;
        if (gameOver_i) begin
            leds_d = {4{blink_q[4]}};
        end else if (simonTurn_i && simonPressed_i) begin
            leds_d = onehot(simonNum_i);
        end else if (pressed_q) begin
            leds_d = onehot(num_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q <= 4'b0000;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign playerNum_o     = num_q;
    assign playerPressed_o = pressed_q;
    assign rand_o          = lfsr_q[1:0];
    assign leds_o          = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_player_pad.sv
`default_nettype none
// Directed bench for simon_player_pad: debounce timing, gating, LEDs, LFSR.
module tb_simon_player_pad;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic       simonTurn, simonPressed, gameOver;
    logic [1:0] simonNum;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic [1:0] rnd;
    logic [3:0] leds;

    int         total = 0;
    int         bad   = 0;
    logic [4:0] blink_m = 5'd0;
    logic [4:0] blink_prev = 5'd0;
    logic [7:0] lfsr_m;

    simon_player_pad #(.DEBOUNCE_TICKS(3), .LFSR_SEED(8'hA5)) dut (
        .clk             (clk),
        .reset           (reset),
        .buttons_i       (buttons),
        .simonTurn_i     (simonTurn),
        .simonNum_i      (simonNum),
        .simonPressed_i  (simonPressed),
        .gameOver_i      (gameOver),
        .playerNum_o     (playerNum),
        .playerPressed_o (playerPressed),
        .rand_o          (rnd),
        .leds_o          (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        blink_prev = blink_m;
        if (reset) blink_m = 5'd0;
        else       blink_m = blink_m + 5'd1;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; buttons = 4'b0; simonTurn = 1'b0; simonPressed = 1'b0;
        simonNum = 2'd0; gameOver = 1'b0;
        ticks(2);
        reset = 1'b0;
        check("rst_pressed", playerPressed, 0);
        check("rst_num", playerNum, 0);
        check("rst_leds", leds, 4'b0000);
        check("rst_rand", rnd, 2'b01);

        // Press bit2: captured at edge k, pressed at k+4, LEDs at k+5.
        buttons = 4'b0100;
        ticks(4);
        check("press_early", playerPressed, 0);
        tick();
        check("press_rise", playerPressed, 1);
        check("press_num", playerNum, 2);
        check("press_leds_lag", leds, 4'b0000);
        tick();
        check("press_leds", leds, 4'b0100);
        ticks(4);
        check("press_hold", playerPressed, 1);

        // One-cycle release glitch must not drop the press.
        buttons = 4'b0000;
        tick();
        buttons = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("glitch_hold", playerPressed, 1);
        end

        // Release: still high through edge r+3, low at r+4.
        buttons = 4'b0000;
        ticks(4);
        check("rel_hold", playerPressed, 1);
        tick();
        check("rel_fall", playerPressed, 0);
        check("rel_num", playerNum, 2);
        tick();
        check("rel_leds", leds, 4'b0000);

        // Two buttons at once: no press.
        buttons = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("multi_none", playerPressed, 0);
        end
        buttons = 4'b0000;
        ticks(3);

        // Two-cycle tap on bit1 is too short.
        buttons = 4'b0010;
        ticks(2);
        buttons = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("tap_none", playerPressed, 0);
        end
        check("tap_num", playerNum, 2);

        // Simon's turn gates player input and drives the LEDs.
        simonTurn = 1'b1; simonPressed = 1'b1; simonNum = 2'd3;
        buttons = 4'b0001;
        ticks(2);
        check("simon_leds", leds, 4'b1000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("simon_gate", playerPressed, 0);
        end
        simonTurn = 1'b0; simonPressed = 1'b0;
        buttons = 4'b0000;
        ticks(3);

        // Press bit0, then gameOver aborts it on the next edge.
        buttons = 4'b0001;
        ticks(6);
        check("go_pre_pressed", playerPressed, 1);
        check("go_pre_num", playerNum, 0);
        check("go_pre_leds", leds, 4'b0001);
        gameOver = 1'b1;
        tick();
        check("go_drop", playerPressed, 0);
        check("go_leds0", leds, {4{blink_prev[4]}});
        for (int i = 0; i < 40; i++) begin
            tick();
            check("go_blink", leds, {4{blink_prev[4]}});
            check("go_idle", playerPressed, 0);
        end

        // Press again, then reset mid-press drops it on the same edge.
        gameOver = 1'b0;
        ticks(6);
        check("re_press", playerPressed, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        buttons = 4'b0000;
        check("rst_mid", playerPressed, 0);
        check("rst_mid_num", playerNum, 0);
        check("rst_seed", dut.lfsr_q, 8'hA5);

        // LFSR runs a full 255-cycle period from the seed.
        lfsr_m = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            tick();
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            check("lfsr_seq", dut.lfsr_q, lfsr_m);
            check("lfsr_nz", dut.lfsr_q != 8'h00, 1);
            check("rand", rnd, lfsr_m[1:0]);
        end
        check("lfsr_period", dut.lfsr_q, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
